instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
//
// PURPOSE
// - Fetch stage between the program counter and decode. Samples the current PC,
//   runs a req/ack read on instruction memory and registers the returned word.
// - Presents that word to decode with a valid/ready handshake.
// - Pulses the increment request back to the program counter once per accepted fetch.
// - Supports flush on branch/jump: any in-flight fetch is discarded and fetching
//   restarts from the newly loaded PC.
//
// PARAMETERS
// - ADDR_W  13  PC / instruction memory address width
// - DATA_W  16  instruction word width
//
// PORTS
// - i_clk          in   1       system clock, rising edge
// - i_rst          in   1       asynchronous reset, active-low
// - i_run          in   1       1 = fetch enabled; 0 = stall in IDLE (halt)
// - i_PC           in   ADDR_W  current PC from program counter
// - o_incPC        out  1       1-cycle pulse: advance PC
// - i_flush        in   1       PC being reloaded; discard current fetch
// - o_memReq       out  1       memory read request, held until ack
// - o_memAddr      out  ADDR_W  read address, stable while o_memReq=1
// - i_memAck       in   1       1-cycle pulse; i_memData valid this cycle
// - i_memData      in   DATA_W  read data
// - o_instr        out  DATA_W  fetched instruction
// - o_instrPC      out  ADDR_W  address o_instr was fetched from
// - o_instrValid   out  1       o_instr/o_instrPC valid
// - i_instrReady   in   1       decode accepts when valid & ready
//
// BEHAVIOUR
// - Reset values (async, immediate on i_rst=0): state=IDLE; discard flag=0;
//   all outputs 0.
// - States: IDLE, REQ, HOLD. All outputs registered.
// - IDLE -> REQ when i_run=1. On the transition: o_memAddr<=i_PC, o_memReq<=1.
// - REQ, ack with no flush and no discard:
//   - o_instr<=i_memData, o_instrPC<=o_memAddr, o_instrValid<=1.
//   - o_memReq<=0, o_incPC<=1 for exactly 1 cycle.
//   - Next state HOLD. Latency: ack in cycle N -> valid and incPC in N+1.
// - HOLD: o_instrValid stays 1 and o_instr stays stable until valid & ready.
//   - On accept: valid<=0.
//   - If i_run=1: go to REQ and latch o_memAddr<=i_PC, which is already incremented.
//   - Otherwise go to IDLE.
// - Flush:
//   - i_flush=1 in any state clears o_instrValid next cycle.
//   - Flush has priority over i_instrReady and over i_memAck in the same cycle.
//   - A flush in REQ before the ack sets discard. The outstanding request cannot
//     be aborted: o_memReq holds until ack. The acked data is then dropped,
//     with no incPC and no valid. Next state is REQ with o_memAddr<=i_PC.
//   - A flush in HOLD or IDLE goes to REQ (if i_run=1) using i_PC from the cycle
//     after flush deasserts.
// - i_memAck outside REQ: ignored. i_run=0 mid-REQ: the request completes
//   normally, then the FSM parks in IDLE after the accept.
// - Address wrap: PC wrap (0x1FFF->0x0000) is owned by the program counter.
//   The fetch passes ADDR_W bits through unmodified.
// - Reset mid-operation: everything clears at once. A late ack after reset
//   is ignored (state IDLE).
//
// CONFIGURATION
// - FETCH_PREFETCH_EN defined:
//   - Adds a 1-entry prefetch buffer. While in HOLD, the next request (PC already
//     incremented) is issued; its ack fills the buffer and pulses o_incPC.
//   - On accept, a full buffer moves to o_instr the next cycle (back-to-back
//     valid), and a new request issues.
//   - Flush clears the buffer and discards any outstanding request, as above.
// - Not defined: at most one instruction in flight or held; no request is issued
//   while HOLD.
//
// TESTING
// - Reset, then i_run=1, PC=0x0000. Memory acks after 2 cycles, data 0xA5A5 ->
//   o_instr=0xA5A5, o_instrPC=0, valid=1, incPC pulse of exactly 1 cycle.
// - i_instrReady=0 for 5 cycles -> o_instr held, no second o_memReq. Without the
//   macro: ready=1 -> next request at addr 0x0001.
// - i_flush during REQ (ack 1 cycle later, PC reloaded to 0x0100) -> acked data
//   dropped, no incPC; next request addr=0x0100.
// - i_flush and i_instrReady in the same HOLD cycle -> valid drops and the
//   instruction counts as not delivered. i_flush and i_memAck in the same cycle
//   -> data dropped.
// - PC=0x1FFF fetch then increment -> o_instrPC=0x1FFF, next o_memAddr=0x0000.
//   i_rst=0 mid-REQ -> all outputs 0 immediately; late ack ignored.
// - With FETCH_PREFETCH_EN, ready held 1 and 0-wait memory -> one valid
//   instruction per ack, consecutive o_instrPC 0,1,2,3.

Source files
------------

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage that sits between the program counter and decode. It samples
// the current PC, reads instruction memory with a req/ack handshake,
// registers the returned word and presents it to decode with a valid/ready
// handshake. For every instruction fetched it pulses o_incPC once to advance
// the program counter. A flush abandons the current fetch and restarts from
// the reloaded PC.
//
// Optional build macro:
//   FETCH_PREFETCH_EN  - adds a 1-entry prefetch buffer. While an instruction
//                        is held for decode, the next word is requested and
//                        parked in the buffer.
//
// Parameters:
//   ADDR_W  PC / instruction memory address width
//   DATA_W  instruction word width
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous reset, active low
//   i_run         1 = fetch enabled, 0 = park in IDLE
//   i_PC          current PC from the program counter
//   o_incPC       1-cycle pulse: advance PC
//   i_flush       PC is being reloaded; drop the current fetch
//   o_memReq      memory read request, held until ack
//   o_memAddr     read address, stable while o_memReq = 1
//   i_memAck      1-cycle pulse, i_memData valid in that cycle
//   i_memData     read data
//   o_instr       fetched instruction
//   o_instrPC     address o_instr was fetched from
//   o_instrValid  o_instr / o_instrPC valid
//   i_instrReady  decode accepts when valid & ready
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic [ADDR_W-1:0] i_PC,
  output logic              o_incPC,
  input  logic              i_flush,
  output logic              o_memReq,
  output logic [ADDR_W-1:0] o_memAddr,
  input  logic              i_memAck,
  input  logic [DATA_W-1:0] i_memData,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instrPC,
  output logic              o_instrValid,
  input  logic              i_instrReady
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_reg,    state_next;
  logic                discard_reg,  discard_next;
  logic                mem_req_reg,  mem_req_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   instr_reg,    instr_next;
  logic [ADDR_W-1:0]   instr_pc_reg, instr_pc_next;
  logic                valid_reg,    valid_next;
  logic                inc_pc_reg,   inc_pc_next;

`ifdef FETCH_PREFETCH_EN
  logic                buf_valid_reg, buf_valid_next;
  logic [DATA_W-1:0]   buf_data_reg,  buf_data_next;
  logic [ADDR_W-1:0]   buf_pc_reg,    buf_pc_next;
`endif

  // An ack only counts while a request is actually outstanding.
  logic ack_live;
  logic accept;

  assign ack_live = i_memAck & mem_req_reg;
  assign accept   = valid_reg & i_instrReady;

  always_comb begin
    state_next    = state_reg;
    discard_next  = discard_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    valid_next    = valid_reg;
    inc_pc_next   = 1'b0;
`ifdef FETCH_PREFETCH_EN
    buf_valid_next = buf_valid_reg;
    buf_data_next  = buf_data_reg;
    buf_pc_next    = buf_pc_reg;
`endif

    case (state_reg)
      IDLE: begin
        // While the PC is being reloaded, wait: the new PC is sampled in the
        // first cycle with flush low.
        if (i_run && !i_flush) begin
          state_next    = REQ;
          mem_req_next  = 1'b1;
          mem_addr_next = i_PC;
        end
      end

      REQ: begin
        if (ack_live) begin
          mem_req_next = 1'b0;
          if (i_flush || discard_reg) begin
            // Stale data: drop it, no PC advance. Restart from the reloaded
            // PC unless the reload is still in progress.
            discard_next = 1'b0;
            if (i_run && !i_flush) begin
              state_next    = REQ;
              mem_req_next  = 1'b1;
              mem_addr_next = i_PC;
            end else begin
              state_next = IDLE;
            end
          end else begin
            instr_next    = i_memData;
            instr_pc_next = mem_addr_reg;
            valid_next    = 1'b1;
            inc_pc_next   = 1'b1;
            state_next    = HOLD;
          end
        end else if (i_flush) begin
          // The memory transaction cannot be aborted; remember to drop it.
          discard_next = 1'b1;
        end
      end

      HOLD: begin
`ifdef FETCH_PREFETCH_EN
        if (i_flush) begin
          buf_valid_next = 1'b0;
          if (mem_req_reg && !ack_live) begin
            discard_next = 1'b1;
            state_next   = REQ;
          end else begin
            mem_req_next = 1'b0;
            state_next   = IDLE;
          end
        end else begin
          if (ack_live) begin
            mem_req_next = 1'b0;
            inc_pc_next  = 1'b1;
            if (accept) begin
              // Buffer is necessarily empty while a request is outstanding,
              // so the new word goes straight to the output.
              instr_next    = i_memData;
              instr_pc_next = mem_addr_reg;
            end else begin
              buf_valid_next = 1'b1;
              buf_data_next  = i_memData;
              buf_pc_next    = mem_addr_reg;
            end
          end
          if (accept) begin
            if (buf_valid_reg) begin
              instr_next     = buf_data_reg;
              instr_pc_next  = buf_pc_reg;
              buf_valid_next = 1'b0;
            end else if (!ack_live) begin
              valid_next = 1'b0;
              if (mem_req_reg) begin
                state_next = REQ;
              end else if (i_run && !inc_pc_reg) begin
                state_next    = REQ;
                mem_req_next  = 1'b1;
                mem_addr_next = i_PC;
              end else begin
                state_next = IDLE;
              end
            end
          end else if (!mem_req_reg && !buf_valid_reg && i_run && !inc_pc_reg) begin
            // Prefetch the next word. Waiting one cycle after an o_incPC
            // pulse guarantees i_PC already points at the next instruction.
            mem_req_next  = 1'b1;
            mem_addr_next = i_PC;
          end
        end
`else
        if (i_flush) begin
          state_next = IDLE;
        end else if (accept) begin
          valid_next = 1'b0;
          // If the accept lands in the o_incPC cycle, i_PC has not advanced
          // yet; detour through IDLE so the incremented PC is sampled.
          if (i_run && !inc_pc_reg) begin
            state_next    = REQ;
            mem_req_next  = 1'b1;
            mem_addr_next = i_PC;
          end else begin
            state_next = IDLE;
          end
        end
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Flush wins over ready and ack in every state.
    if (i_flush) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg     <= IDLE;
      discard_reg   <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      instr_reg     <= '0;
      instr_pc_reg  <= '0;
      valid_reg     <= 1'b0;
      inc_pc_reg    <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      buf_valid_reg <= 1'b0;
      buf_data_reg  <= '0;
      buf_pc_reg    <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      discard_reg   <= discard_next;
      mem_req_reg   <= mem_req_next;
      mem_addr_reg  <= mem_addr_next;
      instr_reg     <= instr_next;
      instr_pc_reg  <= instr_pc_next;
      valid_reg     <= valid_next;
      inc_pc_reg    <= inc_pc_next;
`ifdef FETCH_PREFETCH_EN
      buf_valid_reg <= buf_valid_next;
      buf_data_reg  <= buf_data_next;
      buf_pc_reg    <= buf_pc_next;
`endif
    end
  end

  assign o_incPC      = inc_pc_reg;
  assign o_memReq     = mem_req_reg;
  assign o_memAddr    = mem_addr_reg;
  assign o_instr      = instr_reg;
  assign o_instrPC    = instr_pc_reg;
  assign o_instrValid = valid_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Bench for instruction_fetch. The bench owns a program counter model
// (advances on o_incPC, reloaded on flush) and an instruction memory whose
// contents are a fixed function of the address. A per-cycle checker compares
// the DUT against those rules; directed vectors pin exact values.
// Build with FETCH_PREFETCH_EN defined to run the prefetch sequence instead of
// the default sequence.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  logic              clk;
  logic              i_rst;
  logic              i_run;
  logic [ADDR_W-1:0] i_PC;
  logic              o_incPC;
  logic              i_flush;
  logic              o_memReq;
  logic [ADDR_W-1:0] o_memAddr;
  logic              i_memAck;
  logic [DATA_W-1:0] i_memData;
  logic [DATA_W-1:0] o_instr;
  logic [ADDR_W-1:0] o_instrPC;
  logic              o_instrValid;
  logic              i_instrReady;

  int tests     = 0;
  int fails     = 0;
  int delivered = 0;
  int inc_count = 0;
  int wait_cnt  = 0;
  int mem_lat   = 0;
  bit auto_mem  = 0;
  bit chk_en    = 0;

  logic              prev_req  = 1'b0;
  logic              prev_ack  = 1'b0;
  logic              prev_inc  = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  instruction_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_run        (i_run),
    .i_PC         (i_PC),
    .o_incPC      (o_incPC),
    .i_flush      (i_flush),
    .o_memReq     (o_memReq),
    .o_memAddr    (o_memAddr),
    .i_memAck     (i_memAck),
    .i_memData    (i_memData),
    .o_instr      (o_instr),
    .o_instrPC    (o_instrPC),
    .o_instrValid (o_instrValid),
    .i_instrReady (i_instrReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: word at address 0 is 0xA5A5, others derived from address.
  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    if (a == '0) return 16'hA5A5;
    return {3'b101, a} ^ 16'h0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle. The PC model advances at the edge where o_incPC was high.
  task automatic step();
    logic inc;
    inc = o_incPC;
    @(posedge clk);
    #1;
    if (inc) i_PC = i_PC + 13'd1;
    i_memAck = 1'b0;
    if (auto_mem && o_memReq) begin
      if (wait_cnt >= mem_lat) begin
        i_memAck  = 1'b1;
        i_memData = mem_fn(o_memAddr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
  endtask

  // Per-cycle checker against the fetch rules.
  always @(negedge clk) begin
    if (chk_en && i_rst) begin
      if (o_instrValid) check("instr_matches_memory", o_instr, mem_fn(o_instrPC));
      if (prev_req && o_memReq && !prev_ack) check("addr_stable_during_req", o_memAddr, prev_addr);
      if (o_incPC) begin
        inc_count++;
        check("incpc_single_cycle", prev_inc, 1'b0);
`ifndef FETCH_PREFETCH_EN
        check("incpc_fetched_current_pc", o_instrPC, i_PC);
        check("incpc_with_valid", o_instrValid, 1'b1);
`endif
      end
`ifndef FETCH_PREFETCH_EN
      if (o_memReq) check("no_req_while_holding", o_instrValid, 1'b0);
`endif
      if (o_instrValid && i_instrReady && !i_flush) begin
        delivered++;
        $display("[TB] deliver pc=0x%04h instr=0x%04h", o_instrPC, o_instr);
      end
    end
    prev_req  = o_memReq;
    prev_ack  = i_memAck;
    prev_inc  = o_incPC;
    prev_addr = o_memAddr;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_incPC"}, o_incPC, 0);
    check({tag, "_memReq"}, o_memReq, 0);
    check({tag, "_memAddr"}, o_memAddr, 0);
    check({tag, "_instr"}, o_instr, 0);
    check({tag, "_instrPC"}, o_instrPC, 0);
    check({tag, "_valid"}, o_instrValid, 0);
  endtask

  initial begin
    i_rst        = 1'b0;
    i_run        = 1'b0;
    i_PC         = '0;
    i_flush      = 1'b0;
    i_memAck     = 1'b0;
    i_memData    = '0;
    i_instrReady = 1'b0;

    step();
    step();
    check_all_zero("reset");
    $display("[TB] reset state checked");
    i_rst  = 1'b1;
    chk_en = 1'b1;

`ifndef FETCH_PREFETCH_EN
    // Fetch from PC 0, memory acks two cycles after the request.
    i_run = 1'b1;
    i_PC  = 13'h0000;
    step();
    check("t1_req", o_memReq, 1);
    check("t1_addr", o_memAddr, 13'h0000);
    step();
    step();
    i_memAck  = 1'b1;
    i_memData = 16'hA5A5;
    step();
    check("t1_instr", o_instr, 16'hA5A5);
    check("t1_instrPC", o_instrPC, 13'h0000);
    check("t1_valid", o_instrValid, 1);
    check("t1_incPC", o_incPC, 1);
    step();
    check("t1_incPC_one_cycle", o_incPC, 0);
    $display("[TB] fetch pc=0x0000 done");

    // Decode stalls: instruction held, no new request.
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_instr", o_instr, 16'hA5A5);
      check("t2_hold_valid", o_instrValid, 1);
      check("t2_no_req", o_memReq, 0);
      step();
    end
    i_instrReady = 1'b1;
    step();
    i_instrReady = 1'b0;
    check("t2_next_req", o_memReq, 1);
    check("t2_next_addr", o_memAddr, 13'h0001);
    check("t2_valid_dropped", o_instrValid, 0);
    $display("[TB] stall and advance to 0x0001 done");

    // Flush during REQ, ack one cycle later with PC reloaded to 0x0100.
    i_flush = 1'b1;
    i_PC    = 13'h0100;
    step();
    i_flush = 1'b0;
    check("t3_req_held", o_memReq, 1);
    check("t3_addr_held", o_memAddr, 13'h0001);
    i_memAck  = 1'b1;
    i_memData = mem_fn(13'h0001);
    step();
    check("t3_no_incPC", o_incPC, 0);
    check("t3_no_valid", o_instrValid, 0);
    check("t3_restart_req", o_memReq, 1);
    check("t3_restart_addr", o_memAddr, 13'h0100);
    i_memAck  = 1'b1;
    i_memData = mem_fn(13'h0100);
    step();
    check("t3_instrPC", o_instrPC, 13'h0100);
    check("t3_valid", o_instrValid, 1);
    step();
    $display("[TB] flush in REQ done");

    // Flush and ready in the same HOLD cycle: not delivered.
    i_flush      = 1'b1;
    i_instrReady = 1'b1;
    i_PC         = 13'h0200;
    step();
    i_flush      = 1'b0;
    i_instrReady = 1'b0;
    check("t4_valid_cleared", o_instrValid, 0);
    check("t4_no_req_during_flush", o_memReq, 0);
    step();
    check("t4_restart_addr", o_memAddr, 13'h0200);
    check("t4_restart_req", o_memReq, 1);
    $display("[TB] flush with ready done");

    // Flush and ack in the same cycle: data dropped.
    i_flush   = 1'b1;
    i_memAck  = 1'b1;
    i_memData = mem_fn(13'h0200);
    i_PC      = 13'h0300;
    step();
    i_flush = 1'b0;
    check("t5_no_valid", o_instrValid, 0);
    check("t5_no_incPC", o_incPC, 0);
    check("t5_no_req", o_memReq, 0);
    step();
    check("t5_restart_addr", o_memAddr, 13'h0300);
    i_memAck  = 1'b1;
    i_memData = mem_fn(13'h0300);
    step();
    check("t5_instrPC", o_instrPC, 13'h0300);
    i_instrReady = 1'b1;
    step();
    i_instrReady = 1'b0;
    step();
    check("t5_next_addr", o_memAddr, 13'h0301);
    $display("[TB] flush with ack done");

    // Address wrap 0x1FFF -> 0x0000.
    i_flush = 1'b1;
    i_PC    = 13'h1FFF;
    step();
    i_flush   = 1'b0;
    i_memAck  = 1'b1;
    i_memData = mem_fn(13'h0301);
    step();
    check("t6_addr_1fff", o_memAddr, 13'h1FFF);
    i_memAck  = 1'b1;
    i_memData = mem_fn(13'h1FFF);
    step();
    check("t6_instrPC_1fff", o_instrPC, 13'h1FFF);
    check("t6_valid", o_instrValid, 1);
    step();
    i_instrReady = 1'b1;
    step();
    i_instrReady = 1'b0;
    check("t6_wrap_req", o_memReq, 1);
    check("t6_wrap_addr", o_memAddr, 13'h0000);
    $display("[TB] address wrap done");

    // Reset mid-REQ clears at once; a late ack is ignored.
    chk_en = 1'b0;
    #2;
    i_rst = 1'b0;
    #1;
    check_all_zero("t7_async");
    step();
    i_run     = 1'b0;
    i_rst     = 1'b1;
    i_memAck  = 1'b1;
    i_memData = 16'hDEAD;
    step();
    check("t7_late_ack_req", o_memReq, 0);
    check("t7_late_ack_valid", o_instrValid, 0);
    check("t7_late_ack_inc", o_incPC, 0);
    chk_en = 1'b1;
    $display("[TB] reset mid-REQ done");

    // run drops mid-REQ: request completes, FSM parks after the accept.
    i_PC  = 13'h0010;
    i_run = 1'b1;
    step();
    check("t8_addr", o_memAddr, 13'h0010);
    i_run     = 1'b0;
    i_memAck  = 1'b1;
    i_memData = mem_fn(13'h0010);
    step();
    check("t8_instrPC", o_instrPC, 13'h0010);
    check("t8_instr", o_instr, mem_fn(13'h0010));
    i_instrReady = 1'b1;
    step();
    i_instrReady = 1'b0;
    check("t8_parked_req", o_memReq, 0);
    check("t8_parked_valid", o_instrValid, 0);
    step();
    check("t8_still_parked", o_memReq, 0);
    $display("[TB] run drop done");

    check("delivered_count", delivered, 4);
    check("incpc_count", inc_count, 5);
`else
    // Prefetch: ready held high, zero-wait memory -> PCs 0,1,2,3.
    begin
      logic [ADDR_W-1:0] got_pc [4];
      int n;
      n            = 0;
      auto_mem     = 1'b1;
      mem_lat      = 0;
      i_PC         = 13'h0000;
      i_instrReady = 1'b1;
      i_run        = 1'b1;
      for (int c = 0; c < 200 && n < 4; c++) begin
        step();
        if (o_instrValid && i_instrReady) begin
          got_pc[n] = o_instrPC;
          n++;
        end
      end
      check("pf_count_within_budget", n, 4);
      for (int k = 0; k < n; k++) check("pf_sequential_pc", got_pc[k], k);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
